// File: rtl/rift2_wb_bridge.sv
// rift2_wb_bridge: Wishbone classic slave feeding the Rift2 core valid/ready request/response bus.
// Define RIFT2_WB_TIMEOUT_EN to enable the RSP watchdog (error ack after TIMEOUT cycles).
module rift2_wb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFF0_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic        req_we_o,
  output logic [31:0] req_addr_o,
  output logic [31:0] req_wdata_o,
  output logic [3:0]  req_wstrb_o,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_rdata_i,
  input  logic        rsp_err_i,
  output logic        err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, ACK} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        req_valid_q, req_valid_d;
  logic        req_we_q, req_we_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_wstrb_q, req_wstrb_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        abort_q, abort_d;
  logic        hit;
  logic        rsp_done;
  logic [31:0] rsp_data;

`ifdef RIFT2_WB_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`else
  logic        unused_timeout;
  assign unused_timeout = ^TO_LAST;
`endif

  assign hit = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);

  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    dat_d       = dat_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    err_d       = err_q;
    abort_d     = abort_q;
    rsp_done    = 1'b0;
    rsp_data    = '0;
`ifdef RIFT2_WB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (hit) begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            req_we_d    = wbs_we_i;
            req_addr_d  = wbs_adr_i;
            req_wdata_d = wbs_dat_i;
            req_wstrb_d = wbs_sel_i;
            abort_d     = 1'b0;
          end else begin
            state_d = ACK;
            ack_d   = 1'b1;
            dat_d   = '0;
          end
        end
      end
      REQ: begin
        if (!wbs_cyc_i) abort_d = 1'b1;
        if (req_ready_i) begin
          state_d     = RSP;
          req_valid_d = 1'b0;
`ifdef RIFT2_WB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      RSP: begin
        if (!wbs_cyc_i) abort_d = 1'b1;
        if (rsp_valid_i) begin
          rsp_done = 1'b1;
          if (rsp_err_i) begin
            err_d    = 1'b1;
            rsp_data = '1;
          end else begin
            rsp_data = req_we_q ? '0 : rsp_rdata_i;
          end
        end
`ifdef RIFT2_WB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rsp_done = 1'b1;
          err_d    = 1'b1;
          rsp_data = '1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
        // An abandoned Wishbone cycle still drains the core response, but is never acked.
        if (rsp_done) begin
          if (abort_q || !wbs_cyc_i) begin
            state_d = IDLE;
          end else begin
            state_d = ACK;
            ack_d   = 1'b1;
            dat_d   = rsp_data;
          end
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
`ifdef RIFT2_WB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      abort_q     <= abort_d;
`ifdef RIFT2_WB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign req_valid_o = req_valid_q;
  assign req_we_o    = req_we_q;
  assign req_addr_o  = req_addr_q;
  assign req_wdata_o = req_wdata_q;
  assign req_wstrb_o = req_wstrb_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_rift2_wb_bridge.sv
// Scoreboard bench for rift2_wb_bridge: Wishbone master, scripted core responder, decoupled monitor.
module tb_rift2_wb_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] MASK = 32'hFFF0_0000;
  localparam int          TO   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        req_valid, req_ready = 1'b0, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid = 1'b0, rsp_err = 1'b0;
  logic [31:0] rsp_rdata = '0;
  logic        err, busy;

  always #5 clk = ~clk;

  rift2_wb_bridge #(.BASE_ADDR(BASE), .ADDR_MASK(MASK), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .req_valid_o(req_valid), .req_ready_i(req_ready), .req_we_o(req_we),
    .req_addr_o(req_addr), .req_wdata_o(req_wdata), .req_wstrb_o(req_wstrb),
    .rsp_valid_i(rsp_valid), .rsp_rdata_i(rsp_rdata), .rsp_err_i(rsp_err),
    .err_o(err), .busy_o(busy)
  );

  typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; } req_t;
  typedef struct { int ready_dly; int rsp_dly; logic [31:0] rdata; logic err; logic no_rsp; } core_t;
  typedef struct { logic [31:0] dat; logic err; } ack_t;

  req_t  exp_req_q[$];
  core_t core_q[$];
  ack_t  exp_ack_q[$];
  int    errors = 0;
  int    checks = 0;
  logic  err_model = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Core responder: follows the script queued with each hit.
  initial begin : core
    core_t c;
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      if (req_valid && core_q.size() > 0) begin
        c = core_q.pop_front();
        repeat (c.ready_dly) @(negedge clk);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        if (!c.no_rsp) begin
          repeat (c.rsp_dly - 1) @(negedge clk);
          rsp_valid = 1'b1;
          rsp_rdata = c.rdata;
          rsp_err   = c.err;
          @(negedge clk);
          rsp_valid = 1'b0;
          rsp_err   = 1'b0;
          rsp_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: samples late in each cycle, when both DUT outputs and bench inputs are settled.
  initial begin : monitor
    logic prev_ack;
    ack_t a;
    req_t r;
    prev_ack = 1'b0;
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      #2;
      if (ack) begin
        check32("ack_one_cycle", {31'd0, prev_ack}, 32'd0);
        if (exp_ack_q.size() == 0) flag("unexpected_ack");
        else begin
          a = exp_ack_q.pop_front();
          check32("ack_data", rdat, a.dat);
          check32("ack_err", {31'd0, err}, {31'd0, a.err});
          check32("ack_busy", {31'd0, busy}, 32'd1);
        end
      end
      if (req_valid) begin
        if (exp_req_q.size() == 0) flag("spurious_req_valid");
        else begin
          r = exp_req_q[0];
          check32("req_addr", req_addr, r.adr);
          check32("req_we", {31'd0, req_we}, {31'd0, r.we});
          check32("req_wdata", req_wdata, r.dat);
          check32("req_wstrb", {28'd0, req_wstrb}, {28'd0, r.sel});
          if (req_ready) void'(exp_req_q.pop_front());
        end
      end
      prev_ack = ack;
    end
  end

  task automatic wb_xfer(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                         input logic [3:0] t_sel, input int rd, input int rsp,
                         input logic [31:0] rdata, input logic t_err, input logic no_rsp,
                         input int abort_at);
    logic hit;
    int   n;
    int   exp_lat;
    ack_t a;
    hit = ((t_adr & MASK) == BASE);
    @(negedge clk);
    if (hit) begin
      exp_req_q.push_back('{t_we, t_adr, t_dat, t_sel});
      core_q.push_back('{rd, rsp, rdata, t_err, no_rsp});
      err_model = err_model | t_err | no_rsp;
      a.dat = (t_err || no_rsp) ? 32'hFFFF_FFFF : (t_we ? 32'd0 : rdata);
      a.err = err_model;
      exp_lat = rd + 2 + (no_rsp ? TO : rsp);
    end else begin
      a.dat = 32'd0;
      a.err = err_model;
      exp_lat = 1;
    end
    if (!(hit && abort_at > 0)) exp_ack_q.push_back(a);
    cyc = 1'b1; stb = 1'b1; we = t_we; adr = t_adr; wdat = t_dat; sel = t_sel;
    n = 0;
    if (hit && abort_at > 0) begin
      repeat (abort_at) @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      while (busy && n < 300) begin
        @(negedge clk);
        n++;
      end
      check32("abort_returns_idle", {31'd0, busy}, 32'd0);
    end else begin
      do begin
        @(negedge clk);
        n++;
      end while (!ack && n < 300);
      if (!ack) begin
        $display("FAIL ack_wait: no ack within %0d cycles for adr %h", n, t_adr);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "ack wait expired");
      end
      check32("ack_latency", n, exp_lat);
      cyc = 1'b0; stb = 1'b0; adr = $urandom; wdat = $urandom;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic        r_we, r_err;
    logic [31:0] r_adr;
    logic [3:0]  r_sel;
    int          r_rd, r_rsp, r_abort;
    repeat (2) @(negedge clk);
    check32("rst_ack", {31'd0, ack}, 32'd0);
    check32("rst_dat", rdat, 32'd0);
    check32("rst_req_valid", {31'd0, req_valid}, 32'd0);
    check32("rst_req_we", {31'd0, req_we}, 32'd0);
    check32("rst_req_addr", req_addr, 32'd0);
    check32("rst_req_wdata", req_wdata, 32'd0);
    check32("rst_req_wstrb", {28'd0, req_wstrb}, 32'd0);
    check32("rst_err", {31'd0, err}, 32'd0);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    wb_xfer(1'b0, 32'h3000_0010, 32'h1111_2222, 4'hF, 0, 1, 32'hA5A5_1234, 1'b0, 1'b0, 0);
    wb_xfer(1'b1, 32'h3000_0020, 32'hCAFE_F00D, 4'b0011, 5, 1, 32'h5555_AAAA, 1'b0, 1'b0, 0);
    wb_xfer(1'b0, 32'h2000_0000, 32'h0, 4'hF, 0, 1, 32'h0, 1'b0, 1'b0, 0);
    wb_xfer(1'b0, 32'h300F_FFFC, 32'h0, 4'hF, 1, 2, 32'h1234_5678, 1'b1, 1'b0, 0);
    wb_xfer(1'b0, 32'h3000_0100, 32'h0, 4'hF, 0, 1, 32'h0BAD_BEEF, 1'b0, 1'b0, 0);
    wb_xfer(1'b0, 32'h3000_0200, 32'h0, 4'hF, 3, 2, 32'hDEAD_0001, 1'b0, 1'b0, 2);
    wb_xfer(1'b0, 32'h3000_0204, 32'h0, 4'hF, 0, 1, 32'h600D_0002, 1'b0, 1'b0, 0);
`ifdef RIFT2_WB_TIMEOUT_EN
    wb_xfer(1'b0, 32'h3000_0300, 32'h0, 4'hF, 1, 1, 32'h0, 1'b0, 1'b1, 0);
    wb_xfer(1'b0, 32'h3000_0304, 32'h0, 4'hF, 0, 1, 32'h7777_8888, 1'b0, 1'b0, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r_we    = 1'($urandom);
      r_sel   = 4'($urandom);
      r_rd    = $urandom_range(0, 4);
      r_rsp   = $urandom_range(1, 4);
      r_abort = 0;
      r_err   = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        r_adr = $urandom;
        if ((r_adr & MASK) == BASE) r_adr = r_adr ^ 32'h8000_0000;
      end else begin
        r_adr = BASE | ($urandom & ~MASK);
        if ($urandom_range(0, 9) == 0) r_abort = $urandom_range(1, r_rd + 1);
        else if (!r_we && $urandom_range(0, 7) == 0) r_err = 1'b1;
      end
      wb_xfer(r_we, r_adr, $urandom, r_sel, r_rd, r_rsp, $urandom, r_err, 1'b0, r_abort);
    end

    repeat (5) @(negedge clk);
    check32("ack_queue_drained", exp_ack_q.size(), 32'd0);
    check32("req_queue_drained", exp_req_q.size(), 32'd0);
    check32("err_sticky_end", {31'd0, err}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
